// File: rtl/cp0.sv
// cp0 - MIPS-style system control coprocessor (coprocessor 0).
//
// Holds the SR, Cause, EPC and PRId registers. It resolves exceptions and
// interrupts arriving at the commit stage, raises a same-cycle request to
// the pipeline and captures the exception state on the following clock edge.
//
// Ports
//   clk          : system clock, all state changes on the rising edge
//   reset        : synchronous active-low reset
//   A            : register address for mfc0 reads and mtc0 writes
//   DIn          : mtc0 write data
//   WE           : mtc0 write enable
//   PC           : address of the instruction at the commit stage
//   BDIn         : that instruction sits in a branch delay slot
//   ExcCodeIn    : exception code from earlier stages, 0 = none
//   Load_Ov_In   : load address error flag
//   Store_Ov_In  : store address error flag
//   Cal_Ov_In    : arithmetic overflow flag
//   HWInt        : external hardware interrupt lines
//   EXLClr       : eret is committing, clears SR.EXL
//   Req          : exception/interrupt request to the pipeline
//   EPCOut       : current EPC value, used as the eret target
//   DOut         : mfc0 read data
module cp0 (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic        Load_Ov_In,
  input  logic        Store_Ov_In,
  input  logic        Cal_Ov_In,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        Req,
  output logic [31:0] EPCOut,
  output logic [31:0] DOut
);

  localparam logic [4:0]  ADDR_SR    = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE = 5'd13;
  localparam logic [4:0]  ADDR_EPC   = 5'd14;
  localparam logic [4:0]  ADDR_PRID  = 5'd15;
  localparam logic [31:0] PRID_VALUE = 32'h2023_0007;

  // Only the architecturally meaningful bits are stored; everything else
  // reads back as zero.
  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_excCode;
  logic [31:0] r_epc;

  logic [4:0]  w_excCode;
  logic        w_intReq;
  logic        w_excReq;
  logic        w_req;
  logic [31:0] w_sr;
  logic [31:0] w_cause;

  // Exception code resolution: an upstream code beats the local overflow
  // flags, which are themselves ordered load, store, arithmetic.
  always_comb begin
    w_excCode = 5'd0;
    if (ExcCodeIn != 5'd0) begin
      w_excCode = ExcCodeIn;
    end else if (Load_Ov_In) begin
      w_excCode = 5'd4;
    end else if (Store_Ov_In) begin
      w_excCode = 5'd5;
    end else if (Cal_Ov_In) begin
      w_excCode = 5'd12;
    end
  end

  // EXL blocks both sources so a handler is never re-entered.
  assign w_intReq = (|(HWInt & r_im)) & r_ie & ~r_exl;
  assign w_excReq = (w_excCode != 5'd0) & ~r_exl;
  assign w_req    = w_intReq | w_excReq;
  assign Req      = w_req;

  assign w_sr    = {16'd0, r_im, 8'd0, r_exl, r_ie};
  assign w_cause = {r_bd, 15'd0, r_ip, 3'd0, r_excCode, 2'd0};

  // Register state. Inside the non-reset branch the later assignments take
  // precedence: a request overrides any mtc0 write, and EXLClr overrides
  // the EXL bit of a simultaneous SR write while leaving IM/IE to DIn.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_im      <= 6'd0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= 6'd0;
      r_excCode <= 5'd0;
      r_epc     <= 32'd0;
    end else begin
      r_ip <= HWInt;
      if (w_req) begin
        r_exl     <= 1'b1;
        r_excCode <= w_intReq ? 5'd0 : w_excCode;
        r_bd      <= BDIn;
        r_epc     <= BDIn ? (PC - 32'd4) : PC;
      end else begin
        if (WE && (A == ADDR_SR)) begin
          r_im  <= DIn[15:10];
          r_exl <= DIn[1];
          r_ie  <= DIn[0];
        end
        if (WE && (A == ADDR_EPC)) begin
          r_epc <= DIn;
        end
        if (EXLClr) begin
          r_exl <= 1'b0;
        end
      end
    end
  end

  // mfc0 read port shows the stored value; same-cycle writes are not
  // forwarded.
  always_comb begin
    DOut = 32'd0;
    case (A)
      ADDR_SR:    DOut = w_sr;
      ADDR_CAUSE: DOut = w_cause;
      ADDR_EPC:   DOut = r_epc;
      ADDR_PRID:  DOut = PRID_VALUE;
      default:    DOut = 32'd0;
    endcase
  end

  assign EPCOut = r_epc;

endmodule

// File: tb/tb_cp0.sv
// tb_cp0 - self-checking bench for cp0.
//
// A table of single-cycle vectors drives the coprocessor; each vector
// carries the expected request level during the cycle and the expected
// register contents after the clock edge. Expected values are queued as
// stimulus is driven and popped as the DUT outputs are sampled. Reset is
// exercised by hand-written sequences at the start and end.
module tb_cp0;

  logic        clk;
  logic        reset;
  logic [4:0]  A;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic        Load_Ov_In;
  logic        Store_Ov_In;
  logic        Cal_Ov_In;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        Req;
  logic [31:0] EPCOut;
  logic [31:0] DOut;

  cp0 dut (
    .clk         (clk),
    .reset       (reset),
    .A           (A),
    .DIn         (DIn),
    .WE          (WE),
    .PC          (PC),
    .BDIn        (BDIn),
    .ExcCodeIn   (ExcCodeIn),
    .Load_Ov_In  (Load_Ov_In),
    .Store_Ov_In (Store_Ov_In),
    .Cal_Ov_In   (Cal_Ov_In),
    .HWInt       (HWInt),
    .EXLClr      (EXLClr),
    .Req         (Req),
    .EPCOut      (EPCOut),
    .DOut        (DOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [31:0] din;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
    logic        lov;
    logic        sov;
    logic        cov;
    logic [5:0]  hw;
    logic        clr;
    logic        expReq;
    logic [4:0]  readA;
    logic [31:0] expRead;
    logic [31:0] expEpc;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic addVec(input logic we, input logic [4:0] a, input logic [31:0] din,
                        input logic [31:0] pc, input logic bd, input logic [4:0] exc,
                        input logic lov, input logic sov, input logic cov,
                        input logic [5:0] hw, input logic clr, input logic expReq,
                        input logic [4:0] readA, input logic [31:0] expRead,
                        input logic [31:0] expEpc);
    vec_t v;
    v.we = we; v.a = a; v.din = din; v.pc = pc; v.bd = bd; v.exc = exc;
    v.lov = lov; v.sov = sov; v.cov = cov; v.hw = hw; v.clr = clr;
    v.expReq = expReq; v.readA = readA; v.expRead = expRead; v.expEpc = expEpc;
    tbl.push_back(v);
  endtask

  task automatic pushExp(input string name, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] act);
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty actual=%h", act);
    end else begin
      e = sb.pop_front();
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s actual=%h expected=%h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic quiet();
    WE = 1'b0; A = 5'd0; DIn = 32'd0; PC = 32'd0; BDIn = 1'b0;
    ExcCodeIn = 5'd0; Load_Ov_In = 1'b0; Store_Ov_In = 1'b0;
    Cal_Ov_In = 1'b0; HWInt = 6'd0; EXLClr = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    WE = v.we; A = v.a; DIn = v.din; PC = v.pc; BDIn = v.bd;
    ExcCodeIn = v.exc; Load_Ov_In = v.lov; Store_Ov_In = v.sov;
    Cal_Ov_In = v.cov; HWInt = v.hw; EXLClr = v.clr;
  endtask

  task automatic readReg(input string name, input logic [4:0] addr, input logic [31:0] exp);
    A = addr;
    #1;
    pushExp(name, exp);
    checkOutput(DOut);
  endtask

  initial begin
    quiet();
    reset = 1'b0;

    // Reset with hostile inputs asserted: reset must dominate all of them.
    WE = 1'b1; A = 5'd12; DIn = 32'hFFFF_FFFF; HWInt = 6'h3F; Cal_Ov_In = 1'b1;
    EXLClr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    quiet();
    #1;
    pushExp("reset_req", 32'd0);
    checkOutput({31'd0, Req});
    pushExp("reset_epcout", 32'd0);
    checkOutput(EPCOut);
    readReg("reset_sr", 5'd12, 32'd0);
    readReg("reset_cause", 5'd13, 32'd0);
    readReg("reset_epc", 5'd14, 32'd0);

    //     we    a      din            pc             bd    exc    lov   sov   cov   hw         clr   req   rdA    expRead        expEpc
    addVec(1'b1, 5'd12, 32'h0000_FC01, 32'h0,         1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 5'd12, 32'h0000_FC01, 32'h0);
    addVec(1'b0, 5'd0,  32'h0,         32'h0000_1000, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 6'b000100, 1'b0, 1'b1, 5'd12, 32'h0000_FC03, 32'h0000_1000);
    addVec(1'b0, 5'd0,  32'h0,         32'h0,         1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 6'b000100, 1'b0, 1'b0, 5'd13, 32'h0000_1000, 32'h0000_1000);
    addVec(1'b0, 5'd0,  32'h0,         32'h0000_2000, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 6'b000100, 1'b0, 1'b0, 5'd14, 32'h0000_1000, 32'h0000_1000);
    addVec(1'b0, 5'd0,  32'h0,         32'h0,         1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 6'b000100, 1'b1, 1'b0, 5'd12, 32'h0000_FC01, 32'h0000_1000);
    addVec(1'b0, 5'd0,  32'h0,         32'h0000_5000, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 6'b000100, 1'b0, 1'b1, 5'd12, 32'h0000_FC03, 32'h0000_5000);
    addVec(1'b0, 5'd0,  32'h0,         32'h0,         1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 5'd13, 32'h0000_0000, 32'h0000_5000);
    addVec(1'b0, 5'd0,  32'h0,         32'h0000_3010, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 6'b000000, 1'b0, 1'b1, 5'd13, 32'h8000_0030, 32'h0000_300C);
    addVec(1'b0, 5'd0,  32'h0,         32'h0,         1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 5'd14, 32'h0000_300C, 32'h0000_300C);
    addVec(1'b0, 5'd0,  32'h0,         32'h0000_0400, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b1, 5'd13, 32'h0000_0028, 32'h0000_0400);
    addVec(1'b0, 5'd0,  32'h0,         32'h0,         1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 5'd12, 32'h0000_FC01, 32'h0000_0400);
    addVec(1'b0, 5'd0,  32'h0,         32'h0000_0404, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b1, 5'd13, 32'h0000_0010, 32'h0000_0404);
    addVec(1'b0, 5'd0,  32'h0,         32'h0,         1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 5'd14, 32'h0000_0404, 32'h0000_0404);
    addVec(1'b0, 5'd0,  32'h0,         32'h0000_0408, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b1, 5'd13, 32'h0000_0014, 32'h0000_0408);
    addVec(1'b1, 5'd12, 32'h0000_FC03, 32'h0,         1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 5'd12, 32'h0000_FC01, 32'h0000_0408);
    addVec(1'b1, 5'd14, 32'h0000_4000, 32'h0000_0600, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 6'b000000, 1'b0, 1'b1, 5'd14, 32'h0000_0600, 32'h0000_0600);
    addVec(1'b0, 5'd0,  32'h0,         32'h0,         1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 5'd13, 32'h0000_0030, 32'h0000_0600);
    addVec(1'b1, 5'd13, 32'hFFFF_FFFF, 32'h0,         1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 5'd13, 32'h0000_0030, 32'h0000_0600);
    addVec(1'b0, 5'd0,  32'h0,         32'h0,         1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 5'd15, 32'h2023_0007, 32'h0000_0600);
    addVec(1'b0, 5'd0,  32'h0,         32'h0,         1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 5'd7,  32'h0000_0000, 32'h0000_0600);
    addVec(1'b0, 5'd0,  32'h0,         32'h0000_0700, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 6'b000001, 1'b0, 1'b1, 5'd13, 32'h8000_0400, 32'h0000_06FC);
    addVec(1'b0, 5'd0,  32'h0,         32'h0,         1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 5'd14, 32'h0000_06FC, 32'h0000_06FC);
    addVec(1'b1, 5'd12, 32'hFFFF_FBFD, 32'h0,         1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 5'd12, 32'h0000_F801, 32'h0000_06FC);
    addVec(1'b0, 5'd0,  32'h0,         32'h0,         1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 6'b000001, 1'b0, 1'b0, 5'd13, 32'h8000_0400, 32'h0000_06FC);
    addVec(1'b0, 5'd0,  32'h0,         32'h0000_0800, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 6'b000010, 1'b0, 1'b1, 5'd14, 32'h0000_0800, 32'h0000_0800);
    addVec(1'b0, 5'd0,  32'h0,         32'h0,         1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 5'd12, 32'h0000_F801, 32'h0000_0800);
    addVec(1'b0, 5'd0,  32'h0,         32'h0000_0000, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, 6'b000000, 1'b0, 1'b1, 5'd14, 32'hFFFF_FFFC, 32'hFFFF_FFFC);

    // Inputs change 1 ns after a rising edge; outputs are sampled mid-cycle.
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      #2;
      pushExp($sformatf("v%0d_req", i), {31'd0, tbl[i].expReq});
      checkOutput({31'd0, Req});
      @(posedge clk);
      #1;
      quiet();
      readReg($sformatf("v%0d_read", i), tbl[i].readA, tbl[i].expRead);
      pushExp($sformatf("v%0d_epcout", i), tbl[i].expEpc);
      checkOutput(EPCOut);
    end

    // Reset taken mid-handler with exception and interrupt inputs active.
    WE = 1'b1; A = 5'd14; DIn = 32'h1234_5678; Cal_Ov_In = 1'b1; HWInt = 6'h3F;
    PC = 32'h0000_0900;
    reset = 1'b0;
    #1;
    pushExp("exl_blocks_req", 32'd0);
    checkOutput({31'd0, Req});
    @(posedge clk);
    #1;
    reset = 1'b1;
    quiet();
    #1;
    pushExp("midreset_req", 32'd0);
    checkOutput({31'd0, Req});
    pushExp("midreset_epcout", 32'd0);
    checkOutput(EPCOut);
    readReg("midreset_sr", 5'd12, 32'd0);
    readReg("midreset_cause", 5'd13, 32'd0);
    readReg("midreset_epc", 5'd14, 32'd0);

    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_leftover actual=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-low reset; 0 at a rising clk edge resets all state.
REQ-003 A  input  5  coprocessor register address for mfc0 read and mtc0 write.
REQ-004 DIn  input  32  mtc0 write data.
REQ-005 WE  input  1  mtc0 write enable.
REQ-006 PC  input  32  address of the instruction currently at the commit (M) stage.
REQ-007 BDIn  input  1  that instruction is in a branch delay slot.
REQ-008 ExcCodeIn  input  5  exception code from earlier pipeline stages; 0 means none.
REQ-009 Load_Ov_In, Store_Ov_In, Cal_Ov_In  input  1 each  address/arith overflow flags from the ALU stage.
REQ-010 HWInt  input  6  external hardware interrupt lines.
REQ-011 EXLClr  input  1  eret committing; clears SR.EXL.
REQ-012 Req  output  1  exception/interrupt request to the pipeline (flush, redirect to handler).
REQ-013 EPCOut  output  32  current EPC register value (eret target).
REQ-014 DOut  output  32  mfc0 read data.

Function
REQ-015 Registers: SR (A=12): IM=bits[15:10], EXL=bit1, IE=bit0, other bits read 0; Cause (A=13): BD=bit31, IP=bits[15:10], ExcCode=bits[6:2], other bits 0; EPC (A=14): 32 bits; PRId (A=15): constant 32'h2023_0007.
REQ-016 Exception code resolution, priority high to low: ExcCodeIn!=0 -> ExcCodeIn; Load_Ov_In -> 4 (AdEL); Store_Ov_In -> 5 (AdES); Cal_Ov_In -> 12 (Ov); else 0.
REQ-017 IntReq = (|(HWInt & SR.IM)) & SR.IE & !SR.EXL, combinational.
REQ-018 ExcReq = (resolved code != 0) & !SR.EXL, combinational.
REQ-019 Req = IntReq | ExcReq, combinational, zero-cycle latency from inputs.
REQ-020 Interrupt wins when IntReq and ExcReq coincide; latched ExcCode = 0 for an interrupt.
REQ-021 On a clk edge with Req=1: SR.EXL<=1; Cause.ExcCode<=code per REQ-020; Cause.BD<=BDIn; EPC<=BDIn ? PC-4 : PC (32-bit wrap-around subtraction).
REQ-022 Cause.IP<=HWInt every cycle, regardless of Req, WE or EXL.
REQ-023 mtc0: WE=1 and Req=0 writes DIn to SR (masked to IM/EXL/IE) at A=12 or EPC at A=14; writes to Cause, PRId and unimplemented addresses are ignored.
REQ-024 Req=1 has priority over WE in the same cycle; the mtc0 write is dropped.
REQ-025 EXLClr=1 and Req=0: SR.EXL<=0 at next edge; EXLClr with WE to SR in the same cycle: EXLClr wins for EXL only, other SR bits take DIn.
REQ-026 While SR.EXL=1, Req stays 0 for all exception and interrupt inputs (no nesting).
REQ-027 DOut = combinational read of register at A; unimplemented addresses return 0; a write in the same cycle is not forwarded (old value shown).
REQ-028 EPCOut = EPC register; updated value visible the cycle after the capture edge.

Reset
REQ-029 reset=0 at a rising edge: SR, Cause and EPC cleared to 0; Req=0 and EPCOut=0 the following cycle; reset has priority over Req, WE and EXLClr.
REQ-030 Reset asserted mid-handler (EXL=1) clears EXL; no request is latched in the reset cycle.

Verification
REQ-031 Reset, then mtc0 A=12 DIn=32'h0000_FC01, then HWInt=6'b000100 -> Req=1 same cycle; next cycle SR=32'h0000_FC03, Cause.ExcCode=0, Cause.IP=6'b000100, EPC=PC.
REQ-032 Cal_Ov_In=1, PC=32'h0000_3010, BDIn=1 -> Req=1; then Cause=32'h8000_0030, EPC=32'h0000_300C.
REQ-033 ExcCodeIn=10 with Load_Ov_In=1 -> latched ExcCode=10; Load_Ov_In alone -> 4; Store_Ov_In alone -> 5.
REQ-034 With EXL=1: Cal_Ov_In=1 and unmasked HWInt -> Req=0, EPC unchanged; EXLClr=1 -> EXL=0 next cycle, pending interrupt raises Req.
REQ-035 WE=1 A=14 DIn=32'h0000_4000 with Cal_Ov_In=1 -> write dropped, EPC=PC; WE=1 A=13 -> Cause unchanged; read A=15 -> 32'h2023_0007; A=7 -> 0.
REQ-036 reset=0 while EXL=1 and Req pending -> all registers 0 after the edge, Req=0.
